iir_direct_seq: RTL and testbench
=================================

IIR_DIRECT_SEQ -- requirements
Module: iir_direct_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning sample and coefficient width (signed two's complement, 4..16).
REQ-002 SHALL have parameter ORDER, default 2, meaning number of feedback taps (1..4).
REQ-003 SHALL have parameter FRAC, default W-2, meaning coefficient fractional bits (Q format; 1.0 = 2^FRAC).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port in_valid / in_ready / in_data, input / output / input, 1 / 1 / W, sample input handshake.
REQ-007 SHALL have port out_valid / out_ready / out_data, output / input / output, 1 / 1 / W, result output handshake.
REQ-008 SHALL have port coef_we / coef_idx / coef_data, input, 1 / clog2(ORDER+1) / W, write coefficient a_k, k = coef_idx in 1..ORDER.
REQ-009 SHALL have port hist_clr, input, 1, zero the y history.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 SHALL compute y[n] = x[n] + sum_{k=1..ORDER} (a_k * y[n-k]) >>> FRAC, using a signed 2W-bit product and an accumulator of 2W+clog2(ORDER+1) bits (no intermediate overflow).
REQ-012 SHALL align x as x<<FRAC in the accumulator, apply one arithmetic right shift by FRAC after the sum (floor rounding), then reduce to W bits per REQ-024/025.
REQ-013 SHALL implement FSM IDLE -> MAC -> OUT -> IDLE: IDLE has in_ready=1; a transfer (in_valid & in_ready) captures x and enters MAC.
REQ-014 SHALL spend exactly ORDER cycles in MAC, one tap per cycle through a single shared multiplier, taps in order k=1..ORDER.
REQ-015 SHALL assert out_valid in OUT on cycle ORDER+1 after the input transfer; out_data holds constant until out_ready; OUT->IDLE on out_valid & out_ready.
REQ-016 SHALL shift the history (y[n-1] <= result, y[n-k] <= y[n-k+1]) in the same cycle as the OUT transfer, never earlier.
REQ-017 SHALL keep in_ready low outside IDLE; no sample is accepted during MAC/OUT, and none is dropped or overwritten.
REQ-018 SHALL honour coef_we only in IDLE and only for coef_idx 1..ORDER; writes outside IDLE or with idx 0/out of range are ignored.
REQ-019 SHALL, when coef_we and an input transfer occur in the same IDLE cycle, apply the new coefficient first, so it is used for that sample.
REQ-020 SHALL honour hist_clr only in IDLE, zeroing all y[n-k]; hist_clr coincident with an input transfer clears before that sample's computation.

Reset
REQ-021 SHALL on rst: FSM=IDLE, in_ready=1 on the following cycle, out_valid=0, out_data=0, busy=0, all history=0, all a_k=0.
REQ-022 SHALL let rst mid-MAC or mid-OUT abandon the sample without updating history or producing out_valid.
REQ-023 SHALL give rst priority over every other input in the same cycle.

Configuration
REQ-024 SHALL, with macro IIR_DIRECT_SEQ_SAT_EN defined, saturate the result to [-2^(W-1), 2^(W-1)-1] before output and history storage.
REQ-025 SHALL, without IIR_DIRECT_SEQ_SAT_EN, truncate (two's-complement wrap) the result to W bits; all other behaviour is identical.

Structure
REQ-026 SHALL place the FSM state enum, the accumulator-width function and the SAT min/max constants in shared package iir_pkg.
REQ-027 SHALL instantiate one combinational signed Baugh-Wooley multiplier sub-module bw_mult_n (parameter W, 2W-bit product) as the only multiplier.

Verification (W=8, FRAC=6, 1.0=64)
REQ-028 SHALL cover ORDER=1, a1=32, impulse x=64 then 0,0,0 -> out_data 64, 32, 16, 8; each out_valid 2 cycles after its input transfer.
REQ-029 SHALL cover ORDER=1, a1=64, x=100 twice -> 100 then 127 with SAT_EN; 100 then -56 without.
REQ-030 SHALL cover ORDER=2, a1=64, a2=-32, x=64 then 0,0 -> 64, 64, 32.
REQ-031 SHALL cover out_ready held low 5 cycles in OUT -> out_data stable, in_ready=0, busy=1; coef_we during that window leaves a_k unchanged.
REQ-032 SHALL cover rst asserted in the first MAC cycle -> no out_valid; next impulse x=64 yields 64 with zeroed history and coefficients.
REQ-033 SHALL cover hist_clr with an input transfer in the same cycle (a1=32, prior y=64) -> output equals x alone.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the sequential direct-form IIR filter:
// FSM state encoding, accumulator width and saturation bounds.
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Width that holds x<<FRAC plus ORDER full-width products without overflow.
    function automatic int acc_width(input int w, input int order);
        return 2 * w + $clog2(order + 1);
    endfunction

    // Largest W-bit two's-complement value.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest W-bit two's-complement value.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/iir_direct_seq_bw_mult_n.sv
// Combinational signed W x W -> 2W multiplier built from a Baugh-Wooley
// partial-product array (sign-row/column terms inverted, two correction ones).
module bw_mult_n #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    localparam logic [2*W-1:0] ONE  = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] CORR = (ONE << W) | (ONE << (2*W-1));

    logic [2*W-1:0] sum;
    logic           pp;

    // Accumulate every weighted partial product, then add the correction constant
    always_comb begin
        sum = '0;
        pp  = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp = a[i] & b[j];
                if ((i == W-1) != (j == W-1)) begin
                    pp = ~pp;
                end
                sum = sum + ({{(2*W-1){1'b0}}, pp} << (i + j));
            end
        end
        sum = sum + CORR;
    end

    assign p = sum;

endmodule

// File: rtl/iir_direct_seq.sv
// Sequential direct-form IIR: y[n] = x[n] + sum_k (a_k * y[n-k]) >>> FRAC,
// one tap per cycle through a single shared multiplier.
// Build option: define IIR_DIRECT_SEQ_SAT_EN to saturate the result to W bits;
// otherwise the result wraps.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; out_data is held constant while out_valid is high and out_ready low.
module iir_direct_seq
    import iir_pkg::*;
#(
    parameter int W     = 8,
    parameter int ORDER = 2,
    parameter int FRAC  = W - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    input  logic                         coef_we,
    input  logic [$clog2(ORDER+1)-1:0]   coef_idx,
    input  logic [W-1:0]                 coef_data,
    input  logic                         hist_clr,
    output logic                         busy
);

    localparam int IW = $clog2(ORDER + 1);
    localparam int AW = acc_width(W, ORDER);
`ifdef IIR_DIRECT_SEQ_SAT_EN
    localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(W));
    localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(W));
`endif

    state_t                 state;
    state_t                 state_next;
    logic signed [W-1:0]    coef [ORDER];
    logic signed [W-1:0]    hist [ORDER];
    logic [IW-1:0]          tap;
    logic                   last_tap;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   sum;
    logic signed [W-1:0]    result;
    logic signed [W-1:0]    out_reg;
    logic signed [W-1:0]    mul_a;
    logic signed [W-1:0]    mul_b;
    logic signed [2*W-1:0]  prod;
`ifdef IIR_DIRECT_SEQ_SAT_EN
    logic signed [AW-1:0]   shifted;
`endif

    assign last_tap = (tap == IW'(ORDER - 1));
    assign out_data = out_reg;

    // State register; reset returns to IDLE and abandons any sample in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                if (last_tap) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Select coefficient and history word for the current tap
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < ORDER; i++) begin
            if (tap == IW'(i)) begin
                mul_a = coef[i];
                mul_b = hist[i];
            end
        end
    end

    bw_mult_n #(.W(W)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Accumulate the tap product, then floor-shift and reduce to W bits
    always_comb begin
        sum = acc + {{(AW-2*W){prod[2*W-1]}}, prod};
`ifdef IIR_DIRECT_SEQ_SAT_EN
        shifted = sum >>> FRAC;
        if (shifted > SAT_HI) begin
            result = SAT_HI[W-1:0];
        end else if (shifted < SAT_LO) begin
            result = SAT_LO[W-1:0];
        end else begin
            result = shifted[W-1:0];
        end
`else
        result = W'(sum >>> FRAC);
`endif
    end

    // Coefficients, history and accumulator; configuration only lands in IDLE,
    // so a write coincident with an input transfer is seen by that sample's taps
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            tap     <= '0;
            out_reg <= '0;
            for (int i = 0; i < ORDER; i++) begin
                coef[i] <= '0;
                hist[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    for (int i = 0; i < ORDER; i++) begin
                        if (coef_we && coef_idx == IW'(i + 1)) begin
                            coef[i] <= coef_data;
                        end
                        if (hist_clr) begin
                            hist[i] <= '0;
                        end
                    end
                    if (in_valid) begin
                        acc <= AW'($signed(in_data)) <<< FRAC;
                        tap <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= sum;
                    tap <= tap + IW'(1);
                    if (last_tap) begin
                        out_reg <= result;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        hist[0] <= out_reg;
                        for (int i = 1; i < ORDER; i++) begin
                            hist[i] <= hist[i-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_direct_seq.sv
// Bench for iir_direct_seq: one ORDER=1 and one ORDER=2 instance (W=8, FRAC=6)
// checked against an arithmetic model of the recurrence.
`timescale 1ns/1ps
module tb_iir_direct_seq;

  localparam int W     = 8;
  localparam int FRAC  = 6;
  localparam int NOLIT = -9999;
`ifdef IIR_DIRECT_SEQ_SAT_EN
  localparam int Y_OVF = 127;
`else
  localparam int Y_OVF = -56;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        in_valid, in_ready, out_valid, out_ready, coef_we, hist_clr, busy;
  logic [1:0][W-1:0] in_data, out_data, coef_data;
  logic [1:0][1:0]   coef_idx;

  iir_direct_seq #(.W(W), .ORDER(1), .FRAC(FRAC)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .coef_we(coef_we[0]), .coef_idx(coef_idx[0][0:0]), .coef_data(coef_data[0]),
    .hist_clr(hist_clr[0]), .busy(busy[0])
  );

  iir_direct_seq #(.W(W), .ORDER(2), .FRAC(FRAC)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .coef_we(coef_we[1]), .coef_idx(coef_idx[1]), .coef_data(coef_data[1]),
    .hist_clr(hist_clr[1]), .busy(busy[1])
  );

  int checks   = 0;
  int failures = 0;

  // model state: index d = instance (ORDER = d+1), k = tap 1..ORDER
  int m_a [2][5];
  int m_y [2][5];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int reduce(input longint v);
`ifdef IIR_DIRECT_SEQ_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return int'(v);
`else
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
`endif
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 5; k++) begin
        m_a[d][k] = 0;
        m_y[d][k] = 0;
      end
  endfunction

  function automatic void model_write(input int d, input int idx, input int val);
    if (idx >= 1 && idx <= d + 1) m_a[d][idx] = val;
  endfunction

  function automatic int model_step(input int d, input int x);
    longint acc;
    int y;
    acc = longint'(x) * 64;
    for (int k = 1; k <= d + 1; k++) acc += longint'(m_a[d][k]) * longint'(m_y[d][k]);
    y = reduce(acc >>> FRAC);
    for (int k = d + 1; k >= 2; k--) m_y[d][k] = m_y[d][k-1];
    m_y[d][1] = y;
    return y;
  endfunction

  // scoreboard compare: every cycle an output is presented it must match the head
  always @(negedge clk) begin
    logic [W-1:0] e;
    for (int d = 0; d < 2; d++) begin
      if (!rst && out_valid[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL spurious_out inst%0d: got out_valid=1 data=%0d, expected no output",
                   d, $signed(out_data[d]));
        end else begin
          e = (d == 0) ? exp_q0[0] : exp_q1[0];
          chk($sformatf("out_data_inst%0d", d), int'($signed(out_data[d])), int'($signed(e)));
          if (out_ready[d]) begin
            if (d == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
          end
        end
      end
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic write_coef(input int d, input int idx, input int val);
    coef_we[d] = 1'b1; coef_idx[d] = idx[1:0]; coef_data[d] = val[7:0];
    model_write(d, idx, val);
    @(posedge clk); #1;
    coef_we[d] = 1'b0;
  endtask

  task automatic clear_hist(input int d);
    hist_clr[d] = 1'b1;
    for (int k = 0; k < 5; k++) m_y[d][k] = 0;
    @(posedge clk); #1;
    hist_clr[d] = 1'b0;
  endtask

  task automatic send(input int d, input int x, input bit clr, input int cidx, input int cval,
                      input int hold, input bit hold_we, input int lit);
    int n;
    int y;
    logic [W-1:0] yv;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", int'(in_ready[d]), 1);
    in_valid[d] = 1'b1; in_data[d] = x[7:0]; hist_clr[d] = clr;
    if (cidx != 0) begin
      coef_we[d] = 1'b1; coef_idx[d] = cidx[1:0]; coef_data[d] = cval[7:0];
      model_write(d, cidx, cval);
    end
    if (clr) for (int k = 0; k < 5; k++) m_y[d][k] = 0;
    y  = model_step(d, x);
    yv = y[7:0];
    if (d == 0) exp_q0.push_back(yv); else exp_q1.push_back(yv);
    if (lit != NOLIT) chk("model_literal", y, lit);
    @(posedge clk); #1;
    in_valid[d] = 1'b0; hist_clr[d] = 1'b0; coef_we[d] = 1'b0;
    chk("in_ready_mac", int'(in_ready[d]), 0);
    chk("busy_mac", int'(busy[d]), 1);
    n = 0;
    while (out_valid[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency_edges", n, d + 1);
    for (int h = 0; h < hold; h++) begin
      if (hold_we && h == 1) begin
        coef_we[d] = 1'b1; coef_idx[d] = 2'd1; coef_data[d] = 8'd5;
      end
      @(posedge clk); #1;
      coef_we[d] = 1'b0;
      chk("out_valid_held", int'(out_valid[d]), 1);
      chk("in_ready_out", int'(in_ready[d]), 0);
      chk("busy_out", int'(busy[d]), 1);
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk("idle_after_accept", int'(in_ready[d]), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = '0; out_ready = '0; coef_we = '0; hist_clr = '0;
    in_data = '0; coef_data = '0; coef_idx = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", int'(in_ready[d]), 1);
      chk("rst_out_valid", int'(out_valid[d]), 0);
      chk("rst_out_data", int'(out_data[d]), 0);
      chk("rst_busy", int'(busy[d]), 0);
    end

    // ORDER=1 impulse, a1=0.5
    write_coef(0, 1, 32);
    send(0, 64, 0, 0, 0, 0, 0, 64);
    send(0, 0,  0, 0, 0, 0, 0, 32);
    send(0, 0,  0, 0, 0, 0, 0, 16);
    send(0, 0,  0, 0, 0, 0, 0, 8);

    // overflow: clear history and set a1=1.0 on the same cycle as the first sample
    send(0, 100, 1, 1, 64, 0, 0, 100);
    send(0, 100, 0, 0, 0, 0, 0, Y_OVF);

    // stalled output with an ignored coefficient write, then confirm a1 unchanged
    send(0, 0, 0, 0, 0, 5, 1, Y_OVF);
    send(0, 0, 0, 0, 0, 0, 0, Y_OVF);

    // floor rounding with a coefficient written alongside the sample that uses it
    clear_hist(0);
    send(0, -3, 0, 0, 0, 0, 0, -3);
    send(0, 0,  0, 1, 32, 0, 0, -2);

    // history clear coincident with a transfer
    clear_hist(0);
    send(0, 64, 0, 0, 0, 0, 0, 64);
    send(0, 10, 1, 0, 0, 0, 0, 10);

    // ORDER=2: a1=1.0, a2=-0.5; out-of-range indices must be ignored
    write_coef(1, 1, 64);
    write_coef(1, 2, -32);
    write_coef(1, 3, 77);
    write_coef(1, 0, 77);
    send(1, 64, 0, 0, 0, 0, 0, 64);
    send(1, 0,  0, 0, 0, 0, 0, 64);
    send(1, 0,  0, 0, 0, 0, 0, 32);
    send(1, 0,  0, 0, 0, 0, 0, 0);
    send(1, -7, 0, 0, 0, 0, 0, -23);

    // reset during the first MAC cycle abandons the sample
    in_valid[1] = 1'b1; in_data[1] = 8'd50;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    chk("busy_before_abort", int'(busy[1]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_in_ready", int'(in_ready[1]), 1);
    chk("abort_busy", int'(busy[1]), 0);
    chk("abort_out_data", int'(out_data[1]), 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_out_valid", int'(out_valid[1]), 0);
      @(posedge clk); #1;
    end
    send(1, 64, 0, 0, 0, 0, 0, 64);
    send(1, 0,  0, 0, 0, 0, 0, 0);
    send(0, 64, 0, 0, 0, 0, 0, 64);
    send(0, 0,  0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("queue0_drained", exp_q0.size(), 0);
    chk("queue1_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
